data_mem_multiport: RTL and testbench

- Parametrised successor of the input-activation data memory for the Winograd CNN datapath.
- Loads a full tile of input words through the scan path, then serves NUM_RD independent read ports with fixed latency.
- Tracks load progress and completion with a small FSM, suppresses reads during load, and flags out-of-range addresses.
- Storage is a behavioural array with no reset of contents; it sits between the scan/loader front end and the Winograd input-transform controllers.

---
 rtl/data_mem_multiport.sv | 157 +++++++++++++++
 tb/tb_data_mem_multiport.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_multiport.sv
// data_mem_multiport
//   Input-activation tile memory for the Winograd datapath. A full tile is
//   streamed in through the scan path, one word per cycle, and then NUM_RD
//   independent read ports serve it with fixed latency.
//
//   Optional build macro: MEM_OUT_REG_EN
//     When defined, an extra register stage is added on rd_data_out,
//     rd_valid_out and rd_oob_out, so read latency becomes 2 cycles. Full
//     throughput is kept.
//
// Ports
//   clk           clock (also the scan clock)
//   reset         synchronous, active-high reset
//   scan_in       word written during load
//   scan_enable   load strobe, one word per cycle while high
//   scan_done     high once all DEPTH words are written
//   scan_count    words written in the current load
//   rd_addr_in    packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_valid_in   per-port read request
//   rd_data_out   packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_valid_out  per-port read data valid
//   rd_oob_out    per-port out-of-range flag, qualified by rd_valid_out
module data_mem_multiport #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        scan_in,
    input  logic                     scan_enable,
    output logic                     scan_done,
    output logic [ADDR_W:0]          scan_count,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_in,
    input  logic [NUM_RD-1:0]        rd_valid_in,
    output logic [NUM_RD*DATA_W-1:0] rd_data_out,
    output logic [NUM_RD-1:0]        rd_valid_out,
    output logic [NUM_RD-1:0]        rd_oob_out
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t              state, state_nxt;
    logic                en_q;       // scan_enable from the previous cycle
    logic                start;      // this cycle begins a new load
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic                rd_accept;

    logic [DATA_W-1:0]   mem [DEPTH];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            en_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            en_q  <= scan_enable;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, READY: if (start) state_nxt = LOAD;
            LOAD: begin
                if (!scan_enable)             state_nxt = IDLE;
                else if (scan_count == LAST_C) state_nxt = READY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // From READY a held-high strobe must drop for a cycle before it can
    // start another load, so a long strobe cannot wrap around and
    // overwrite the tile it just finished.
    always_comb begin
        start     = (state == IDLE  && scan_enable) ||
                    (state == READY && scan_enable && !en_q);
        scan_done = (state == READY);
        wr_en     = !reset && (start || (state == LOAD && scan_enable));
        wr_addr   = start ? '0 : scan_count[ADDR_W-1:0];
        // Reads are blocked for the whole load, including the entry cycle,
        // so a read can never race a write.
        rd_accept = (state != LOAD) && !start;
    end

    always_ff @(posedge clk) begin
        if (reset)                             scan_count <= '0;
        else if (start)                        scan_count <= (ADDR_W+1)'(1);
        else if (state == LOAD && scan_enable) scan_count <= scan_count + (ADDR_W+1)'(1);
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= scan_in;
    end

    // ---------------- read ports ----------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              oob;
        logic              req;
        logic              vld_s1, oob_s1;
        logic [DATA_W-1:0] data_s1;

        assign addr = rd_addr_in[i*ADDR_W +: ADDR_W];
        assign oob  = {1'b0, addr} >= DEPTH_C;
        assign req  = rd_valid_in[i] && rd_accept;

        // Data holds across idle cycles; the oob flag only lives with valid.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_s1  <= 1'b0;
                oob_s1  <= 1'b0;
                data_s1 <= '0;
            end else begin
                vld_s1 <= req;
                oob_s1 <= req && oob;
                if (req) data_s1 <= oob ? '0 : mem[addr];
            end
        end

`ifdef MEM_OUT_REG_EN
        logic              vld_s2, oob_s2;
        logic [DATA_W-1:0] data_s2;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_s2  <= 1'b0;
                oob_s2  <= 1'b0;
                data_s2 <= '0;
            end else begin
                vld_s2  <= vld_s1;
                oob_s2  <= oob_s1;
                data_s2 <= data_s1;
            end
        end

        assign rd_valid_out[i]                 = vld_s2;
        assign rd_oob_out[i]                   = oob_s2;
        assign rd_data_out[i*DATA_W +: DATA_W] = data_s2;
`else
        assign rd_valid_out[i]                 = vld_s1;
        assign rd_oob_out[i]                   = oob_s1;
        assign rd_data_out[i*DATA_W +: DATA_W] = data_s1;
`endif
    end

endmodule

// File: tb/tb_data_mem_multiport.sv
// Bench for data_mem_multiport: two instances (DEPTH 256 and DEPTH 200)
// share one stimulus stream; a behavioural model predicts every output
// every cycle, and directed sequences/tables cover the load and read rules.
module tb_data_mem_multiport;

    localparam int DW = 512;
    localparam int AW = 8;
    localparam int NR = 2;
`ifdef MEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [DW-1:0]       scan_in;
    logic                scan_enable;
    logic [NR*AW-1:0]    rd_addr_in;
    logic [NR-1:0]       rd_valid_in;

    logic [1:0]              done;
    logic [1:0][AW:0]        cnt;
    logic [1:0][NR*DW-1:0]   rdata;
    logic [1:0][NR-1:0]      rvld;
    logic [1:0][NR-1:0]      roob;

    data_mem_multiport #(.DATA_W(DW), .DEPTH(256), .ADDR_W(AW), .NUM_RD(NR)) u0 (
        .clk(clk), .reset(reset), .scan_in(scan_in), .scan_enable(scan_enable),
        .scan_done(done[0]), .scan_count(cnt[0]), .rd_addr_in(rd_addr_in),
        .rd_valid_in(rd_valid_in), .rd_data_out(rdata[0]), .rd_valid_out(rvld[0]),
        .rd_oob_out(roob[0]));

    data_mem_multiport #(.DATA_W(DW), .DEPTH(200), .ADDR_W(AW), .NUM_RD(NR)) u1 (
        .clk(clk), .reset(reset), .scan_in(scan_in), .scan_enable(scan_enable),
        .scan_done(done[1]), .scan_count(cnt[1]), .rd_addr_in(rd_addr_in),
        .rd_valid_in(rd_valid_in), .rd_data_out(rdata[1]), .rd_valid_out(rvld[1]),
        .rd_oob_out(roob[1]));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [7:0] v);
        return {64{v}};
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          v;
        logic          o;
        logic [DW-1:0] d;
    } rd_t;

    int            dep [2] = '{256, 200};
    logic [DW-1:0] mmem [2][256];
    rd_t           s1 [2][NR];
    rd_t           s2 [2][NR];
    int            m_cnt [2];
    bit            m_load [2];
    bit            m_done [2];
    bit            m_prev [2];

    task automatic model_edge();
        bit starting, rd_ok;
        int a;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_load[d] = 0; m_done[d] = 0; m_cnt[d] = 0; m_prev[d] = 0;
                for (int p = 0; p < NR; p++) begin
                    s1[d][p] = '0;
                    s2[d][p] = '0;
                end
            end else begin
                starting = scan_enable && !m_load[d] && !(m_done[d] && m_prev[d]);
                rd_ok    = !m_load[d] && !starting;
                for (int p = 0; p < NR; p++) begin
                    s2[d][p] = s1[d][p];
                    a = int'(rd_addr_in[p*AW +: AW]);
                    if (rd_valid_in[p] && rd_ok) begin
                        s1[d][p].v = 1'b1;
                        s1[d][p].o = (a >= dep[d]);
                        s1[d][p].d = (a >= dep[d]) ? '0 : mmem[d][a];
                    end else begin
                        s1[d][p].v = 1'b0;
                        s1[d][p].o = 1'b0;
                    end
                end
                if (starting) begin
                    mmem[d][0] = scan_in;
                    m_cnt[d] = 1; m_load[d] = 1; m_done[d] = 0;
                end else if (m_load[d]) begin
                    if (scan_enable) begin
                        mmem[d][m_cnt[d]] = scan_in;
                        m_cnt[d]++;
                        if (m_cnt[d] == dep[d]) begin
                            m_load[d] = 0;
                            m_done[d] = 1;
                        end
                    end else begin
                        m_load[d] = 0;
                    end
                end
                m_prev[d] = scan_enable;
            end
        end
    endtask

    function automatic rd_t exp_of(input int d, input int p);
`ifdef MEM_OUT_REG_EN
        return s2[d][p];
`else
        return s1[d][p];
`endif
    endfunction

    task automatic check_all();
        rd_t e;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("m_cnt%0d", d), DW'(cnt[d]), DW'(m_cnt[d]));
            chk($sformatf("m_done%0d", d), DW'(done[d]), DW'(m_done[d]));
            for (int p = 0; p < NR; p++) begin
                e = exp_of(d, p);
                chk($sformatf("m_vld%0d_%0d", d, p), DW'(rvld[d][p]), DW'(e.v));
                chk($sformatf("m_oob%0d_%0d", d, p), DW'(roob[d][p]), DW'(e.o));
                chk($sformatf("m_data%0d_%0d", d, p), rdata[d][p*DW +: DW], e.d);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // ---------------- directed read table ----------------
    typedef struct {
        logic [7:0] a0;
        logic [7:0] a1;
        logic       o0;   // expected oob on the DEPTH=200 instance
        logic       o1;
    } vec_t;

    vec_t tbl [6];
    bit   rd_seen;

    initial begin
        tbl[0] = '{8'd0,   8'd7,   1'b0, 1'b0};
        tbl[1] = '{8'd255, 8'd255, 1'b1, 1'b1};
        tbl[2] = '{8'd42,  8'd42,  1'b0, 1'b0};
        tbl[3] = '{8'd210, 8'd199, 1'b1, 1'b0};
        tbl[4] = '{8'd199, 8'd210, 1'b0, 1'b1};
        tbl[5] = '{8'd7,   8'd0,   1'b0, 1'b0};

        reset = 1'b1; scan_enable = 1'b0; scan_in = '0;
        rd_addr_in = '0; rd_valid_in = '0;
        cycle();
        cycle();
        for (int d = 0; d < 2; d++) begin
            chk("rst_cnt",  DW'(cnt[d]),   '0);
            chk("rst_done", DW'(done[d]),  '0);
            chk("rst_vld",  DW'(rvld[d]),  '0);
            chk("rst_oob",  DW'(roob[d]),  '0);
            chk("rst_data", DW'(rdata[d]), '0);
        end
        reset = 1'b0;

        // Partial load of 10 words; reads on the entry cycle and mid-load are dropped.
        rd_seen = 0;
        rd_addr_in = {8'd3, 8'd3};
        for (int i = 0; i < 10; i++) begin
            scan_enable = 1'b1;
            scan_in     = rep(8'(i) ^ 8'hA5);
            rd_valid_in = (i == 0 || i == 4) ? 2'b11 : 2'b00;
            cycle();
            rd_seen |= (|rvld[0]) | (|rvld[1]);
        end
        scan_enable = 1'b0; rd_valid_in = '0;
        cycle();
        rd_seen |= (|rvld[0]) | (|rvld[1]);
        for (int d = 0; d < 2; d++) begin
            chk("part_cnt",  DW'(cnt[d]),  DW'(9'd10));
            chk("part_done", DW'(done[d]), '0);
        end
        cycle();
        rd_seen |= (|rvld[0]) | (|rvld[1]);
        chk("load_rd_drop", DW'(rd_seen), '0);

        // Full load with index pattern; DEPTH=200 instance must stop at 200.
        for (int i = 0; i < 256; i++) begin
            scan_enable = 1'b1;
            scan_in     = rep(8'(i));
            cycle();
            if (i == 254) begin
                chk("full_cnt_pre",  DW'(cnt[0]),  DW'(9'd255));
                chk("full_done_pre", DW'(done[0]), '0);
            end
            if (i == 199) begin
                chk("d200_cnt",  DW'(cnt[1]),  DW'(9'd200));
                chk("d200_done", DW'(done[1]), DW'(1'b1));
            end
        end
        chk("full_cnt",  DW'(cnt[0]),  DW'(9'd256));
        chk("full_done", DW'(done[0]), DW'(1'b1));
        scan_in = rep(8'hEE);
        cycle();   // strobe still high: no restart
        chk("hold_cnt",  DW'(cnt[0]),  DW'(9'd256));
        chk("hold_done", DW'(done[0]), DW'(1'b1));
        chk("hold_cnt1", DW'(cnt[1]),  DW'(9'd200));
        scan_enable = 1'b0;
        cycle();

        // Table-driven reads.
        for (int t = 0; t < 6; t++) begin
            rd_addr_in  = {tbl[t].a1, tbl[t].a0};
            rd_valid_in = 2'b11;
            cycle();
            rd_valid_in = 2'b00;
`ifdef MEM_OUT_REG_EN
            cycle();
`endif
            chk($sformatf("tbl%0d_vld0", t), DW'(rvld[0]), DW'(2'b11));
            chk($sformatf("tbl%0d_vld1", t), DW'(rvld[1]), DW'(2'b11));
            chk($sformatf("tbl%0d_oob0", t), DW'(roob[0]), '0);
            chk($sformatf("tbl%0d_oob1", t), DW'(roob[1]), DW'({tbl[t].o1, tbl[t].o0}));
            chk($sformatf("tbl%0d_d0p0", t), rdata[0][0 +: DW],  rep(tbl[t].a0));
            chk($sformatf("tbl%0d_d0p1", t), rdata[0][DW +: DW], rep(tbl[t].a1));
            chk($sformatf("tbl%0d_d1p0", t), rdata[1][0 +: DW],  tbl[t].o0 ? '0 : rep(tbl[t].a0));
            chk($sformatf("tbl%0d_d1p1", t), rdata[1][DW +: DW], tbl[t].o1 ? '0 : rep(tbl[t].a1));
        end

        // Dual-port streaming: port0 0..15, port1 15..0, no bubbles.
        for (int i = 0; i < 16 + LAT; i++) begin
            if (i < 16) begin
                rd_addr_in  = {8'(15 - i), 8'(i)};
                rd_valid_in = 2'b11;
            end else begin
                rd_valid_in = 2'b00;
            end
            cycle();
            if (i >= LAT - 1 && i < 16 + LAT - 1) begin
                chk($sformatf("strm%0d_vld", i), DW'(rvld[0]), DW'(2'b11));
                chk($sformatf("strm%0d_p0", i), rdata[0][0 +: DW],  rep(8'(i - (LAT - 1))));
                chk($sformatf("strm%0d_p1", i), rdata[0][DW +: DW], rep(8'(15 - (i - (LAT - 1)))));
            end
        end

        // Random traffic with occasional short loads.
        for (int n = 0; n < 400; n++) begin
            scan_enable = ($urandom_range(0, 9) == 0);
            for (int w = 0; w < DW / 32; w++) scan_in[w*32 +: 32] = $urandom;
            rd_valid_in = 2'($urandom);
            rd_addr_in  = 16'($urandom);
            cycle();
        end

        // Reset with a read in flight after a 100-word partial load.
        scan_enable = 1'b0; rd_valid_in = '0;
        cycle();
        for (int i = 0; i < 100; i++) begin
            scan_enable = 1'b1;
            scan_in     = rep(~8'(i));
            cycle();
        end
        chk("mid_cnt", DW'(cnt[0]), DW'(9'd100));
        scan_enable = 1'b0;
        cycle();
        rd_addr_in  = {8'd5, 8'd5};
        rd_valid_in = 2'b10;
        cycle();
        rd_valid_in = 2'b00;
        reset = 1'b1;
        cycle();
        for (int d = 0; d < 2; d++) begin
            chk("mrst_cnt",  DW'(cnt[d]),  '0);
            chk("mrst_done", DW'(done[d]), '0);
            chk("mrst_vld",  DW'(rvld[d]), '0);
        end
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            scan_enable = 1'b1;
            scan_in     = rep(~8'(i));
            cycle();
        end
        scan_enable = 1'b0;
        cycle();
        rd_addr_in  = {8'd50, 8'd50};
        rd_valid_in = 2'b11;
        cycle();
        rd_valid_in = 2'b00;
`ifdef MEM_OUT_REG_EN
        cycle();
`endif
        chk("reload_w50_u0", rdata[0][0 +: DW],  rep(8'hCD));
        chk("reload_w50_u1", rdata[1][DW +: DW], rep(8'hCD));
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
